vu_meter: RTL and testbench



---
 rtl/vu_meter_if.sv | 32 +++
 rtl/vu_meter.sv | 193 +++++++++++++++++++
 tb/tb_vu_meter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vu_meter_if.sv
// vu_meter_if: sample input and meter output bundle for the level meter.
// The master side (the equaliser / bench) drives samples and clears.
// The slave side (vu_meter) returns the meter readings.
interface vu_meter_if;
    logic               i_done;
    logic signed [15:0] i_data;
    logic               i_clear;
    logic        [15:0] o_avg;
    logic        [3:0]  o_level;
    logic        [3:0]  o_peak;
    logic               o_update;

    modport master (
        output i_done,
        output i_data,
        output i_clear,
        input  o_avg,
        input  o_level,
        input  o_peak,
        input  o_update
    );

    modport slave (
        input  i_done,
        input  i_data,
        input  i_clear,
        output o_avg,
        output o_level,
        output o_peak,
        output o_update
    );
endinterface

// File: rtl/vu_meter.sv
// vu_meter: rectifies samples, averages magnitude and tracks the peak over a
// 2^WIN_LOG2-sample window, then maps both to 4-bit log levels.
// Optional feature macro: VU_PEAK_HOLD_EN enables peak hold/decay with an
// 8-bit hold counter; without it o_peak is the peak level of each window.
module vu_meter #(
    parameter int WIN_LOG2     = 10,
    parameter int HOLD_WINDOWS = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    vu_meter_if.slave   bus
);

    localparam int ACC_W = 15 + WIN_LOG2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    // Elaboration-time guard on the legal parameter ranges.
    generate
        if (WIN_LOG2 < 2 || WIN_LOG2 > 16) begin : g_bad_win
            $error("vu_meter: WIN_LOG2 out of range 2..16");
        end
        if (HOLD_WINDOWS < 0 || HOLD_WINDOWS > 255) begin : g_bad_hold
            $error("vu_meter: HOLD_WINDOWS out of range 0..255");
        end
    endgenerate

    // Level map: 0 for zero, otherwise position of highest set bit plus one.
    function automatic logic [3:0] level_of(input logic [14:0] x);
        logic [3:0] lv;
        lv = 4'd0;
        for (int i = 0; i < 15; i++) begin
            if (x[i]) lv = 4'(i + 1);
        end
        return lv;
    endfunction

    state_t              state_reg;
    state_t              state_next;

    logic [ACC_W-1:0]    acc_reg;
    logic [14:0]         wmax_reg;
    logic [WIN_LOG2-1:0] cnt_reg;

    // Snapshot keeps only the bits that survive the divide by 2^WIN_LOG2.
    logic [14:0]         snap_avg_reg;
    logic [14:0]         snap_max_reg;

    logic [14:0]         avg_reg;
    logic [3:0]          level_reg;
    logic [3:0]          peak_reg;

    logic [15:0]         neg_data;
    logic [14:0]         abs_val;
    logic [ACC_W-1:0]    acc_sum;
    logic [14:0]         max_new;
    logic                win_end;
    logic [3:0]          lvl;
    logic [3:0]          pk;

    // Rectify with saturation of the most negative code.
    always_comb begin
        neg_data = -bus.i_data;
        abs_val  = 15'd0;
        if (!bus.i_data[15]) begin
            abs_val = bus.i_data[14:0];
        end else if (bus.i_data == 16'sh8000) begin
            abs_val = 15'h7fff;
        end else begin
            abs_val = neg_data[14:0];
        end
    end

    assign acc_sum = acc_reg + {{WIN_LOG2{1'b0}}, abs_val};
    assign max_new = (abs_val > wmax_reg) ? abs_val : wmax_reg;
    assign win_end = bus.i_done && (cnt_reg == {WIN_LOG2{1'b1}});
    assign lvl     = level_of(snap_avg_reg);
    assign pk      = level_of(snap_max_reg);

    // Window accumulation and snapshot capture; the next window starts at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_reg      <= '0;
            wmax_reg     <= '0;
            cnt_reg      <= '0;
            snap_avg_reg <= '0;
            snap_max_reg <= '0;
        end else if (bus.i_clear) begin
            acc_reg      <= '0;
            wmax_reg     <= '0;
            cnt_reg      <= '0;
            snap_avg_reg <= '0;
            snap_max_reg <= '0;
        end else if (bus.i_done) begin
            if (win_end) begin
                snap_avg_reg <= acc_sum[ACC_W-1 -: 15];
                snap_max_reg <= max_new;
                acc_reg      <= '0;
                wmax_reg     <= '0;
                cnt_reg      <= '0;
            end else begin
                acc_reg      <= acc_sum;
                wmax_reg     <= max_new;
                cnt_reg      <= cnt_reg + 1'b1;
            end
        end
    end

    // Pipeline state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg <= S_IDLE;
        end else if (bus.i_clear) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Pipeline next-state: a window end starts one calc/out pass.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (win_end) state_next = S_CALC;
            S_CALC:  state_next = S_OUT;
            S_OUT:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

`ifdef VU_PEAK_HOLD_EN
    localparam logic [7:0] HOLD_INIT = 8'(HOLD_WINDOWS);

    logic [7:0] hold_reg;
    logic [3:0] peak_dec;

    assign peak_dec = peak_reg - 4'd1;

    // Output registers with peak hold then one-level-per-window decay.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            avg_reg   <= '0;
            level_reg <= '0;
            peak_reg  <= '0;
            hold_reg  <= '0;
        end else if (bus.i_clear) begin
            avg_reg   <= '0;
            level_reg <= '0;
            peak_reg  <= '0;
            hold_reg  <= '0;
        end else if (state_reg == S_CALC) begin
            avg_reg   <= snap_avg_reg;
            level_reg <= lvl;
            if (pk >= peak_reg) begin
                peak_reg <= pk;
                hold_reg <= HOLD_INIT;
            end else if (hold_reg != 8'd0) begin
                hold_reg <= hold_reg - 8'd1;
            end else begin
                // pk < peak_reg here, so peak_reg is at least 1.
                peak_reg <= (peak_dec > pk) ? peak_dec : pk;
            end
        end
    end
`else
    // Output registers; peak simply follows each window's peak level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            avg_reg   <= '0;
            level_reg <= '0;
            peak_reg  <= '0;
        end else if (bus.i_clear) begin
            avg_reg   <= '0;
            level_reg <= '0;
            peak_reg  <= '0;
        end else if (state_reg == S_CALC) begin
            avg_reg   <= snap_avg_reg;
            level_reg <= lvl;
            peak_reg  <= pk;
        end
    end
`endif

    assign bus.o_avg    = {1'b0, avg_reg};
    assign bus.o_level  = level_reg;
    assign bus.o_peak   = peak_reg;
    assign bus.o_update = (state_reg == S_OUT);

endmodule

// File: tb/tb_vu_meter.sv
// tb_vu_meter: directed-vector bench for vu_meter (WIN_LOG2=2, HOLD_WINDOWS=2).
// Peak expectations follow the VU_PEAK_HOLD_EN macro when it is defined.
module tb_vu_meter;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    logic        s_upd;
    logic [15:0] s_avg;
    logic [3:0]  s_lvl;
    logic [3:0]  s_pk;

    vu_meter_if bus ();

    vu_meter #(
        .WIN_LOG2     (2),
        .HOLD_WINDOWS (2)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive inputs, sample outputs mid-cycle, advance.
    task automatic cyc(input logic done, input logic [15:0] data, input logic clr);
        bus.i_done  = done;
        bus.i_data  = data;
        bus.i_clear = clr;
        @(negedge clk);
        s_upd = bus.o_update;
        s_avg = bus.o_avg;
        s_lvl = bus.o_level;
        s_pk  = bus.o_peak;
        @(posedge clk);
        #1;
    endtask

    // Four strobes then two idle cycles; returns o_update at T+1 and T+2
    // plus the outputs seen at T+2.
    task automatic feed_window(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d,
                               output logic u1, output logic u2,
                               output logic [15:0] avg, output logic [3:0] lvl,
                               output logic [3:0] pk);
        cyc(1'b1, a, 1'b0);
        cyc(1'b1, b, 1'b0);
        cyc(1'b1, c, 1'b0);
        cyc(1'b1, d, 1'b0);
        cyc(1'b0, 16'd0, 1'b0);
        u1 = s_upd;
        cyc(1'b0, 16'd0, 1'b0);
        u2  = s_upd;
        avg = s_avg;
        lvl = s_lvl;
        pk  = s_pk;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(1'b0, 16'd0, 1'b0);
        cyc(1'b1, 16'd1234, 1'b0);
        n_vec++;
        if (s_avg !== 16'd0 || s_lvl !== 4'd0 || s_pk !== 4'd0 || s_upd !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: avg=%0d lvl=%0d pk=%0d upd=%0b, required all 0",
                     s_avg, s_lvl, s_pk, s_upd);
        end
        rst = 1'b0;
        cyc(1'b0, 16'd0, 1'b0);
    endtask

    task automatic test_basic;
        logic u1, u2;
        logic [15:0] avg;
        logic [3:0] lvl, pk;
        cyc(1'b0, 16'd0, 1'b1);
        feed_window(16'd1000, 16'd1000, 16'd1000, 16'd1000, u1, u2, avg, lvl, pk);
        n_vec++;
        if (u1 !== 1'b0 || u2 !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_latency: upd T+1=%0b T+2=%0b, required 0 then 1", u1, u2);
        end
        n_vec++;
        if (avg !== 16'd1000 || lvl !== 4'd10 || pk !== 4'd10) begin
            n_bad++;
            $display("FAIL basic_values: avg=%0d lvl=%0d pk=%0d, required 1000 10 10", avg, lvl, pk);
        end
        $display("basic: avg=%0d lvl=%0d pk=%0d", avg, lvl, pk);
    endtask

    task automatic test_rectify;
        logic u1, u2;
        logic [15:0] avg;
        logic [3:0] lvl, pk;
        logic [3:0] exp_pk;
        cyc(1'b0, 16'd0, 1'b1);
        feed_window(16'h8000, 16'h8000, 16'h8000, 16'h8000, u1, u2, avg, lvl, pk);
        n_vec++;
        if (u2 !== 1'b1 || avg !== 16'd32767 || lvl !== 4'd15 || pk !== 4'd15) begin
            n_bad++;
            $display("FAIL rectify_sat: upd=%0b avg=%0d lvl=%0d pk=%0d, required 1 32767 15 15",
                     u2, avg, lvl, pk);
        end
        $display("rectify -32768: avg=%0d lvl=%0d pk=%0d", avg, lvl, pk);
        feed_window(16'd0, 16'd0, 16'd0, 16'd0, u1, u2, avg, lvl, pk);
`ifdef VU_PEAK_HOLD_EN
        exp_pk = 4'd15;
`else
        exp_pk = 4'd0;
`endif
        n_vec++;
        if (u2 !== 1'b1 || avg !== 16'd0 || lvl !== 4'd0 || pk !== exp_pk) begin
            n_bad++;
            $display("FAIL rectify_zero: upd=%0b avg=%0d lvl=%0d pk=%0d, required 1 0 0 %0d",
                     u2, avg, lvl, pk, exp_pk);
        end
        $display("rectify zeros: avg=%0d lvl=%0d pk=%0d", avg, lvl, pk);
    endtask

    task automatic test_peak_decay;
        logic u1, u2;
        logic [15:0] avg;
        logic [3:0] lvl, pk;
        logic [3:0] exp_pk [7];
`ifdef VU_PEAK_HOLD_EN
        exp_pk[0] = 4'd15; exp_pk[1] = 4'd15; exp_pk[2] = 4'd15; exp_pk[3] = 4'd14;
        exp_pk[4] = 4'd13; exp_pk[5] = 4'd12; exp_pk[6] = 4'd11;
`else
        exp_pk[0] = 4'd15; exp_pk[1] = 4'd0; exp_pk[2] = 4'd0; exp_pk[3] = 4'd0;
        exp_pk[4] = 4'd0;  exp_pk[5] = 4'd0; exp_pk[6] = 4'd0;
`endif
        cyc(1'b0, 16'd0, 1'b1);
        for (int w = 0; w < 7; w++) begin
            if (w == 0)
                feed_window(16'd16384, 16'd16384, 16'd16384, 16'd16384, u1, u2, avg, lvl, pk);
            else
                feed_window(16'd0, 16'd0, 16'd0, 16'd0, u1, u2, avg, lvl, pk);
            n_vec++;
            if (u2 !== 1'b1 || pk !== exp_pk[w]) begin
                n_bad++;
                $display("FAIL peak_decay[%0d]: upd=%0b pk=%0d, required 1 %0d", w, u2, pk, exp_pk[w]);
            end
            $display("peak window %0d: pk=%0d", w, pk);
        end
    endtask

    task automatic test_mixed;
        logic u1, u2;
        logic [15:0] avg;
        logic [3:0] lvl, pk;
        cyc(1'b0, 16'd0, 1'b1);
        feed_window(16'd100, -16'sd4, 16'd0, 16'd3, u1, u2, avg, lvl, pk);
        n_vec++;
        if (u2 !== 1'b1 || avg !== 16'd26 || lvl !== 4'd5 || pk !== 4'd7) begin
            n_bad++;
            $display("FAIL mixed: upd=%0b avg=%0d lvl=%0d pk=%0d, required 1 26 5 7", u2, avg, lvl, pk);
        end
        $display("mixed: avg=%0d lvl=%0d pk=%0d", avg, lvl, pk);
    endtask

    task automatic test_clear;
        int n_upd;
        logic [15:0] avg;
        logic [3:0] lvl, pk;
        cyc(1'b0, 16'd0, 1'b1);
        n_upd = 0;
        avg = 16'hffff; lvl = 4'hf; pk = 4'hf;
        for (int k = 0; k < 11; k++) begin
            if (k < 2)      cyc(1'b1, 16'd5000, 1'b0);
            else if (k == 2) cyc(1'b1, 16'd5000, 1'b1);
            else if (k < 7) cyc(1'b1, 16'd8, 1'b0);
            else            cyc(1'b0, 16'd0, 1'b0);
            if (s_upd === 1'b1) begin
                n_upd++;
                avg = s_avg; lvl = s_lvl; pk = s_pk;
            end
        end
        n_vec++;
        if (n_upd != 1) begin
            n_bad++;
            $display("FAIL clear_pulses: %0d updates, required 1", n_upd);
        end
        n_vec++;
        if (avg !== 16'd8 || lvl !== 4'd4 || pk !== 4'd4) begin
            n_bad++;
            $display("FAIL clear_values: avg=%0d lvl=%0d pk=%0d, required 8 4 4", avg, lvl, pk);
        end
        $display("clear: updates=%0d avg=%0d lvl=%0d pk=%0d", n_upd, avg, lvl, pk);
    endtask

    task automatic test_back_to_back;
        logic exp_upd;
        cyc(1'b0, 16'd0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            cyc((k <= 12), 16'd2, 1'b0);
            exp_upd = (k == 6 || k == 10 || k == 14);
            n_vec++;
            if (s_upd !== exp_upd) begin
                n_bad++;
                $display("FAIL b2b_upd[cycle %0d]: upd=%0b, required %0b", k, s_upd, exp_upd);
            end
            if (exp_upd) begin
                n_vec++;
                if (s_avg !== 16'd2 || s_lvl !== 4'd2) begin
                    n_bad++;
                    $display("FAIL b2b_values[cycle %0d]: avg=%0d lvl=%0d, required 2 2", k, s_avg, s_lvl);
                end
                $display("b2b cycle %0d: avg=%0d lvl=%0d", k, s_avg, s_lvl);
            end
        end
    endtask

    task automatic test_reset_mid;
        int late_upd;
        cyc(1'b0, 16'd0, 1'b1);
        late_upd = 0;
        for (int k = 1; k <= 16; k++) begin
            rst = (k == 8);
            cyc((k <= 7), 16'd2, 1'b0);
            if (k == 6) begin
                n_vec++;
                if (s_upd !== 1'b1 || s_avg !== 16'd2) begin
                    n_bad++;
                    $display("FAIL rstmid_first: upd=%0b avg=%0d, required 1 2", s_upd, s_avg);
                end
            end
            if (k == 8) begin
                n_vec++;
                if (s_avg !== 16'd0 || s_lvl !== 4'd0 || s_pk !== 4'd0 || s_upd !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rstmid_zero: avg=%0d lvl=%0d pk=%0d upd=%0b, required all 0",
                             s_avg, s_lvl, s_pk, s_upd);
                end
            end
            if (k > 8 && s_upd === 1'b1) late_upd++;
        end
        rst = 1'b0;
        n_vec++;
        if (late_upd != 0) begin
            n_bad++;
            $display("FAIL rstmid_pulses: %0d updates after reset, required 0", late_upd);
        end
        $display("reset mid-window: late updates=%0d", late_upd);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.i_done  = 1'b0;
        bus.i_data  = 16'd0;
        bus.i_clear = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_rectify();
        test_peak_decay();
        test_mixed();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
